multicycle_mips: RTL

Multi-cycle MIPS core: next generation of the team's single-cycle processor. Executes each instruction over 2–5 states through one shared memory port with a ready handshake, so memory may stall for any number of cycles. Parametrised in reset vector, memory-address width and illegal-opcode policy. Adds `bne`, `addi` and a halt state, plus retirement and state visibility for the bench.

---
 rtl/mips_pkg.sv | 70 +++++++
 rtl/mips_mc_control.sv | 117 +++++++++++
 rtl/multicycle_mips.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: encodings, FSM states,
// ALU operations and small decode/execute helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_decode(input logic [5:0] op, input logic [5:0] funct);
    if (op != OP_RTYPE) return ALU_ADD;
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] alu_exec(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB/HALT and
// produces the datapath enables and the memory request strobes.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  input  logic       i_branch_cond,
  output state_t     o_state,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_ir_we,
  output logic       o_pc_inc,
  output logic       o_pc_jump,
  output logic       o_pc_branch,
  output logic       o_decode_we,
  output logic       o_exec_we,
  output logic       o_mdr_we,
  output logic       o_rf_we,
  output logic       o_retire
);

  state_t r_state;
  state_t w_state_next;
  logic   w_legal;
  logic   w_is_branch;
  logic   w_is_ldst;

  assign w_legal     = is_legal(i_opcode, i_funct);
  assign w_is_branch = (i_opcode == OP_BEQ) || (i_opcode == OP_BNE);
  assign w_is_ldst   = (i_opcode == OP_LW) || (i_opcode == OP_SW);
  assign o_state     = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (i_mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        if (i_opcode == OP_J)  w_state_next = S_FETCH;
        else if (!w_legal)     w_state_next = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
        else                   w_state_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_ldst)        w_state_next = S_MEM;
        else if (w_is_branch) w_state_next = S_FETCH;
        else                  w_state_next = S_WB;
      end
      S_MEM:    if (i_mem_ready) w_state_next = (i_opcode == OP_SW) ? S_FETCH : S_WB;
      S_WB:     w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Request strobes are gated by rst so an in-flight access drops at once.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_inc    = 1'b0;
    o_pc_jump   = 1'b0;
    o_pc_branch = 1'b0;
    o_decode_we = 1'b0;
    o_exec_we   = 1'b0;
    o_mdr_we    = 1'b0;
    o_rf_we     = 1'b0;
    o_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req = !rst;
        o_ir_we   = i_mem_ready;
        o_pc_inc  = i_mem_ready;
      end
      S_DECODE: begin
        o_decode_we = 1'b1;
        if (i_opcode == OP_J) begin
          o_pc_jump = 1'b1;
          o_retire  = 1'b1;
        end else if (!w_legal && !TRAP_ON_ILLEGAL) begin
          o_retire = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_branch) begin
          o_pc_branch = i_branch_cond;
          o_retire    = 1'b1;
        end else begin
          o_exec_we = 1'b1;
        end
      end
      S_MEM: begin
        o_mem_req = !rst;
        o_mem_we  = !rst && (i_opcode == OP_SW);
        if (i_mem_ready) begin
          o_mdr_we = (i_opcode == OP_LW);
          o_retire = (i_opcode == OP_SW);
        end
      end
      S_WB: begin
        o_rf_we  = 1'b1;
        o_retire = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core top: datapath registers, register file and ALU around
// the control FSM, sharing one request/ready memory port for fetch and data.
module multicycle_mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MEM_AW          = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [2:0]        state,
  output logic              instr_retired,
  output logic              halted
);

  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
  logic [31:0] r_rf [32];
  logic        r_retired;

  state_t      w_state;
  logic        w_ir_we, w_pc_inc, w_pc_jump, w_pc_branch, w_decode_we, w_exec_we;
  logic        w_mdr_we, w_rf_we, w_retire, w_branch_cond;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_wb_addr;
  logic [31:0] w_imm_ext, w_alu_b, w_alu_result, w_wb_data, w_addr_full;

  assign w_opcode  = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_funct   = r_ir[5:0];
  assign w_imm_ext = sext16(r_ir[15:0]);

  assign w_alu_b       = (w_opcode == OP_RTYPE) ? r_b : w_imm_ext;
  assign w_alu_result  = alu_exec(alu_decode(w_opcode, w_funct), r_a, w_alu_b);
  assign w_branch_cond = (w_opcode == OP_BNE) ? (r_a != r_b) : (r_a == r_b);
  assign w_wb_addr     = (w_opcode == OP_RTYPE) ? w_rd : w_rt;
  assign w_wb_data     = (w_opcode == OP_LW) ? r_mdr : r_aluout;
  assign w_addr_full   = (w_state == S_MEM) ? r_aluout : r_pc;

  mips_mc_control #(
    .TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)
  ) u_control (
    .clk          (clk),
    .rst          (rst),
    .i_opcode     (w_opcode),
    .i_funct      (w_funct),
    .i_mem_ready  (mem_ready),
    .i_branch_cond(w_branch_cond),
    .o_state      (w_state),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_ir_we      (w_ir_we),
    .o_pc_inc     (w_pc_inc),
    .o_pc_jump    (w_pc_jump),
    .o_pc_branch  (w_pc_branch),
    .o_decode_we  (w_decode_we),
    .o_exec_we    (w_exec_we),
    .o_mdr_we     (w_mdr_we),
    .o_rf_we      (w_rf_we),
    .o_retire     (w_retire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_mdr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluout  <= '0;
      r_retired <= 1'b0;
    end else begin
      r_retired <= w_retire;
      if (w_ir_we) r_ir <= mem_rdata;
      if (w_mdr_we) r_mdr <= mem_rdata;
      if (w_pc_inc)         r_pc <= r_pc + 32'd4;
      else if (w_pc_jump)   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
      else if (w_pc_branch) r_pc <= r_aluout;
      // DECODE precomputes the branch target so EXEC only has to compare.
      if (w_decode_we) begin
        r_a      <= r_rf[w_rs];
        r_b      <= r_rf[w_rt];
        r_aluout <= r_pc + (w_imm_ext << 2);
      end else if (w_exec_we) begin
        r_aluout <= w_alu_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_rf_we && (w_wb_addr != 5'd0)) begin
      r_rf[w_wb_addr] <= w_wb_data;
    end
  end

  assign mem_addr      = w_addr_full[MEM_AW-1:0];
  assign mem_wdata     = r_b;
  assign pc            = r_pc;
  assign state         = w_state;
  assign instr_retired = r_retired;
  assign halted        = (w_state == S_HALT);

endmodule
